// File: rtl/led_seq_ctrl.sv
// LED pattern sequencer control: button conditioning, LOAD/RUN step timing,
// pause handling and mode advance (manual via btn_next, automatic via auto_en).
module led_seq_ctrl #(
  parameter int TICK_DIV       = 25000000,
  parameter int STEPS_PER_MODE = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_next,
  input  logic       btn_pause,
  input  logic       auto_en,
  output logic [1:0] mode,
  output logic       step,
  output logic       restart,
  output logic       hold
);

  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam int CW = (STEPS_PER_MODE > 1) ? $clog2(STEPS_PER_MODE) : 1;

  typedef enum logic {LOAD, RUN} state_t;

  state_t        state_reg, state_next;
  logic [1:0]    mode_reg, mode_next;
  logic [PW-1:0] presc_reg, presc_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic          paused_reg, paused_next;

  // Bit 0 = next button, bit 1 = pause button
  logic [1:0] btn_raw;
  logic [1:0] sync1_reg, sync2_reg, prev_reg, btn_edge;

  assign btn_raw = {btn_pause, btn_next};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_btn
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          sync1_reg[gi] <= 1'b0;
          sync2_reg[gi] <= 1'b0;
          prev_reg[gi]  <= 1'b0;
        end else begin
          sync1_reg[gi] <= btn_raw[gi];
          sync2_reg[gi] <= sync1_reg[gi];
          prev_reg[gi]  <= sync2_reg[gi];
        end
      end
      assign btn_edge[gi] = sync2_reg[gi] & ~prev_reg[gi];
    end
  endgenerate

  logic next_edge, pause_edge, presc_last, cnt_last, step_fire;

  assign next_edge  = btn_edge[0];
  assign pause_edge = btn_edge[1];
  assign presc_last = (presc_reg == PW'(TICK_DIV - 1));
  assign cnt_last   = (cnt_reg == CW'(STEPS_PER_MODE - 1));
  assign step_fire  = (state_reg == RUN) && !paused_reg && presc_last;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg  <= LOAD;
      mode_reg   <= 2'd0;
      presc_reg  <= '0;
      cnt_reg    <= '0;
      paused_reg <= 1'b0;
    end else begin
      state_reg  <= state_next;
      mode_reg   <= mode_next;
      presc_reg  <= presc_next;
      cnt_reg    <= cnt_next;
      paused_reg <= paused_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    mode_next   = mode_reg;
    presc_next  = presc_reg;
    cnt_next    = cnt_reg;
    paused_next = paused_reg ^ pause_edge;
    if (state_reg == LOAD) begin
      presc_next = '0;
      cnt_next   = '0;
      state_next = RUN;
    end else begin
      // A manual edge and an auto-advance in the same cycle share one increment
      if (next_edge || (step_fire && cnt_last && auto_en)) begin
        mode_next  = mode_reg + 2'd1;
        state_next = LOAD;
      end else if (step_fire) begin
        presc_next = '0;
        cnt_next   = cnt_last ? '0 : cnt_reg + CW'(1);
      end else if (!paused_reg) begin
        presc_next = presc_reg + PW'(1);
      end
    end
  end

  assign mode    = mode_reg;
  assign step    = step_fire;
  assign restart = (state_reg == LOAD);
  assign hold    = paused_reg;

endmodule

// File: doc/led_seq_ctrl.md
LED_SEQ_CTRL -- requirements
Module: led_seq_ctrl

Interface
REQ-001 SHALL have parameter TICK_DIV, default 25000000: clk cycles per pattern step (min 2).
REQ-002 SHALL have parameter STEPS_PER_MODE, default 16: steps per mode before auto-advance (min 1).
REQ-003 SHALL have port clk  input  1  system clock; all state on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port btn_next  input  1  raw button; rising edge advances the mode.
REQ-006 SHALL have port btn_pause  input  1  raw button; rising edge toggles pause.
REQ-007 SHALL have port auto_en  input  1  level; 1 enables auto mode advance.
REQ-008 SHALL have port mode  output  2  pattern mode for the LED pattern engine.
REQ-009 SHALL have port step  output  1  one-cycle strobe: pattern engine advances one step.
REQ-010 SHALL have port restart  output  1  one-cycle strobe: pattern engine reloads its start pattern.
REQ-011 SHALL have port hold  output  1  level; 1 while paused (engine freezes).

Function
REQ-012 SHALL pass each button through a 2-flop synchronizer plus a previous-value flop; an edge is sync2=1 and prev=0.
REQ-013 SHALL act on a button edge at the 3rd rising clk edge on which the raw input is sampled high, with a held button producing exactly one action.
REQ-014 SHALL implement FSM states LOAD and RUN, plus an independent paused flag.
REQ-015 LOAD SHALL last exactly one cycle, drive restart=1, clear prescaler and step counter, then go to RUN.
REQ-016 RUN, unpaused: prescaler SHALL count 0..TICK_DIV-1 and wrap; step=1 only in the cycle prescaler==TICK_DIV-1.
REQ-017 The first step after LOAD SHALL occur TICK_DIV cycles after the LOAD cycle.
REQ-018 Paused: prescaler and step counter SHALL freeze, step=0, hold=1; unpause resumes from the frozen count.
REQ-019 Step counter SHALL increment on each step, range 0..STEPS_PER_MODE-1.
REQ-020 On a step with step counter==STEPS_PER_MODE-1 and auto_en=1: mode SHALL advance, FSM enters LOAD next cycle.
REQ-021 Under the REQ-020 condition with auto_en=0: step counter SHALL wrap to 0 and mode SHALL be unchanged.
REQ-022 Mode advance SHALL follow 00->01->10->11->00, wrapping modulo 4.
REQ-023 A next edge in RUN, paused or not, SHALL advance the mode and enter LOAD; the paused flag is unchanged.
REQ-024 A next edge coinciding with an auto-advance SHALL advance the mode once only.
REQ-025 A next edge during LOAD SHALL be ignored.
REQ-026 A pause edge SHALL toggle the paused flag in any state, including LOAD.
REQ-027 Simultaneous next and pause edges SHALL both take effect: mode advances, LOAD entered, paused toggles.
REQ-028 restart and step SHALL never be high in the same cycle.
REQ-029 All outputs SHALL be registered or decoded only from registered state.

Reset
REQ-030 Reset assertion SHALL immediately force: mode=00, step=0, hold=0, paused=0, prescaler=0, step counter=0, synchronizer flops=0, FSM=LOAD.
REQ-031 After reset deasserts, the first clk edge SHALL perform LOAD, so restart=1 for one cycle.
REQ-032 Reset mid-operation (any state, paused or not) SHALL produce the same result as REQ-030 with no extra step or restart pulse.

Verification (TICK_DIV=4, STEPS_PER_MODE=3)
REQ-033 Release reset, auto_en=1 -> restart one cycle, steps every 4 cycles; after the 3rd step mode=01 and restart pulses; full run wraps 11->00.
REQ-034 auto_en=0, run 10 steps -> mode stays 00; no restart after the initial one.
REQ-035 Pulse btn_pause mid-count, hold 20 cycles, pulse again -> hold=1, no steps while paused; resumes with the same remaining prescaler count.
REQ-036 Hold btn_next high 50 cycles -> mode advances once, on the 3rd sampled edge; one restart; step counter restarts at 0.
REQ-037 btn_next and btn_pause rising in the same cycle while running -> mode+1, restart, hold=1, no step until unpaused.
REQ-038 Assert reset while paused in mode 10 -> mode=00 and hold=0 immediately; restart follows release.
